// File: rtl/uart_receiver_if.sv
// Receive-side word handshake: the receiver presents data_out/data_valid and
// the consumer answers with data_ready.
interface uart_receiver_if #(
    parameter int WORD_SIZE = 8
);
    logic [WORD_SIZE-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;

    modport master (output data_out, output data_valid, input data_ready);
    modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/uart_receiver.sv
// UART 8N1-style receiver with mid-bit sampling and valid/ready word output.
// Build option UART_RX_OVERRUN_EN adds a sticky overrun flag port.
module uart_receiver #(
    parameter int WORD_SIZE   = 8,
    parameter int PULSE_WIDTH = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            rx,
    uart_receiver_if.master bus,
    output logic            rx_busy,
`ifdef UART_RX_OVERRUN_EN
    output logic            overrun,
`endif
    output logic            frame_err
);
    localparam int HALF = PULSE_WIDTH / 2;
    localparam int CW   = $clog2(PULSE_WIDTH);
    localparam int BW   = (WORD_SIZE > 2) ? $clog2(WORD_SIZE) : 1;
    localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(PULSE_WIDTH - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WORD_SIZE - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state;
    logic [CW-1:0]        clk_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [WORD_SIZE-1:0] shift_reg;
    logic [SYNC_STAGES-1:0] sync;
    logic                 rx_s;

    // Preset to idle-high so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sync <= '1;
        else       sync <= {sync[SYNC_STAGES-2:0], rx};
    end

    assign rx_s    = sync[SYNC_STAGES-1];
    assign rx_busy = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            clk_cnt        <= '0;
            bit_cnt        <= '0;
            shift_reg      <= '0;
            bus.data_out   <= '0;
            bus.data_valid <= 1'b0;
            frame_err      <= 1'b0;
`ifdef UART_RX_OVERRUN_EN
            overrun        <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            if (bus.data_valid && bus.data_ready) begin
                bus.data_valid <= 1'b0;
`ifdef UART_RX_OVERRUN_EN
                overrun        <= 1'b0;
`endif
            end
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state   <= START;
                        clk_cnt <= '0;
                    end
                end
                START: begin
                    if (clk_cnt == HALF_M1) begin
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            clk_cnt <= '0;
                            bit_cnt <= '0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt   <= '0;
                        shift_reg <= {rx_s, shift_reg[WORD_SIZE-1:1]};
                        if (bit_cnt == BIT_LAST) state <= STOP;
                        else                     bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    // Leave mid stop bit so a back-to-back start edge is not missed.
                    if (clk_cnt == CNT_LAST) begin
                        state   <= IDLE;
                        clk_cnt <= '0;
                        if (rx_s) begin
                            bus.data_out   <= shift_reg;
                            bus.data_valid <= 1'b1;
`ifdef UART_RX_OVERRUN_EN
                            if (bus.data_valid && !bus.data_ready) overrun <= 1'b1;
`endif
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: latency, back-to-back, glitch, framing
// error, overwrite/overrun and mid-frame reset.
module tb_uart_receiver;
    localparam int WS = 8;
    localparam int PW = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic rx = 1'b1;
    logic rx_busy, frame_err;
`ifdef UART_RX_OVERRUN_EN
    logic overrun;
`endif

    int checks = 0;
    int errors = 0;
    int ferr_cnt = 0;
    int acc_n = 0;
    logic [WS-1:0] acc [0:15];

    uart_receiver_if #(.WORD_SIZE(WS)) bus ();

    uart_receiver #(.WORD_SIZE(WS), .PULSE_WIDTH(PW), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx        (rx),
        .bus       (bus.master),
        .rx_busy   (rx_busy),
`ifdef UART_RX_OVERRUN_EN
        .overrun   (overrun),
`endif
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) ferr_cnt++;
        if (bus.data_valid && bus.data_ready && acc_n < 16) begin
            acc[acc_n] = bus.data_out;
            acc_n++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bit_time();
        repeat (PW) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WS-1:0] w, input logic stop_bit);
        rx = 1'b0;
        bit_time();
        for (int i = 0; i < WS; i++) begin
            rx = w[i];
            bit_time();
        end
        rx = stop_bit;
        bit_time();
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int first_busy;
        bus.data_ready = 1'b1;
        idle(3);
        chk("reset_valid", {31'd0, bus.data_valid}, 32'd0);
        chk("reset_data", {24'd0, bus.data_out}, 32'd0);
        chk("reset_busy", {31'd0, rx_busy}, 32'd0);
        rstn = 1'b1;
        idle(3);
        chk("idle_busy", {31'd0, rx_busy}, 32'd0);

        // Latency: start at P0+1, first edge sampling rx=0 is P1, valid after P41.
        fork
            send(8'hA5, 1'b1);
        join_none
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!bus.data_valid && n < 100);
        chk("lat_edges", n - 1, 32'd40);
        chk("lat_data", {24'd0, bus.data_out}, 32'hA5);
        idle(1);
        chk("valid_one_cycle", {31'd0, bus.data_valid}, 32'd0);
        chk("lat_ferr", ferr_cnt, 32'd0);
        idle(5);

        // Back-to-back frames.
        acc_n = 0;
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h55, 1'b1);
        send(8'h81, 1'b1);
        idle(20);
        chk("b2b_count", acc_n, 32'd4);
        chk("b2b_w0", {24'd0, acc[0]}, 32'h00);
        chk("b2b_w1", {24'd0, acc[1]}, 32'hFF);
        chk("b2b_w2", {24'd0, acc[2]}, 32'h55);
        chk("b2b_w3", {24'd0, acc[3]}, 32'h81);
        chk("b2b_ferr", ferr_cnt, 32'd0);

        // One-clock glitch.
        acc_n = 0;
        rx = 1'b0;
        idle(1);
        rx = 1'b1;
        first_busy = 0;
        for (int i = 0; i < 8; i++) begin
            idle(1);
            if (rx_busy) first_busy = i + 1;
        end
        chk("glitch_busy_cleared", {31'd0, rx_busy}, 32'd0);
        chk("glitch_busy_bound", {31'd0, first_busy > 0 && first_busy <= 3}, 32'd1);
        chk("glitch_novalid", acc_n, 32'd0);
        chk("glitch_ferr", ferr_cnt, 32'd0);

        // Bad stop bit.
        send(8'h3C, 1'b0);
        idle(10);
        chk("ferr_pulse", ferr_cnt, 32'd1);
        chk("ferr_novalid", acc_n, 32'd0);
        chk("ferr_valid", {31'd0, bus.data_valid}, 32'd0);
        chk("ferr_retain", {24'd0, bus.data_out}, 32'h81);

        // Overwrite with consumer stalled.
        bus.data_ready = 1'b0;
        send(8'h12, 1'b1);
        idle(3);
        chk("ovw_first", {24'd0, bus.data_out}, 32'h12);
`ifdef UART_RX_OVERRUN_EN
        chk("ovr_clear_first", {31'd0, overrun}, 32'd0);
`endif
        send(8'h34, 1'b1);
        idle(3);
        chk("ovw_data", {24'd0, bus.data_out}, 32'h34);
        chk("ovw_valid", {31'd0, bus.data_valid}, 32'd1);
`ifdef UART_RX_OVERRUN_EN
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        idle(4);
        chk("ovr_sticky", {31'd0, overrun}, 32'd1);
`endif
        bus.data_ready = 1'b1;
        idle(1);
        chk("ovw_accepted", {31'd0, bus.data_valid}, 32'd0);
        chk("ovw_acc_word", {24'd0, acc[0]}, 32'h34);
`ifdef UART_RX_OVERRUN_EN
        chk("ovr_cleared", {31'd0, overrun}, 32'd0);
`endif
        idle(4);

        // Reset mid-DATA of 0xC3.
        rx = 1'b0; bit_time();
        rx = 1'b1; bit_time();
        rx = 1'b1; bit_time();
        rx = 1'b0; idle(2);
        chk("pre_rst_busy", {31'd0, rx_busy}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("rst_busy", {31'd0, rx_busy}, 32'd0);
        chk("rst_data", {24'd0, bus.data_out}, 32'd0);
        chk("rst_valid", {31'd0, bus.data_valid}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        rx = 1'b1;
        idle(3);
        rstn = 1'b1;
        idle(3);
        acc_n = 0;
        send(8'h5A, 1'b1);
        idle(8);
        chk("post_rst_count", acc_n, 32'd1);
        chk("post_rst_word", {24'd0, acc[0]}, 32'h5A);
        chk("post_rst_ferr", ferr_cnt, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
